// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the MMIO UART peripheral.
// Holds register offsets, STATUS bit positions, the UART FSM state type
// and the divisor clamp helper.
package mmio_pkg;

    // Byte offsets of the UART registers inside the 16-byte window
    localparam logic [3:0] UART_TXDATA  = 4'h0;
    localparam logic [3:0] UART_RXDATA  = 4'h4;
    localparam logic [3:0] UART_STATUS  = 4'h8;
    localparam logic [3:0] UART_DIVISOR = 4'hC;

    // STATUS register bit positions
    localparam int ST_TX_BUSY    = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;

    // Smallest cycles-per-bit the shifters can run at
    localparam logic [15:0] UART_DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Raise a too-small divisor to the minimum the FSMs can handle
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < UART_DIV_MIN) ? UART_DIV_MIN : v;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer for mmio_uart.
// With MMIO_UART_RX_FIFO_EN defined it is a 4-entry FIFO with wrapping
// 2-bit pointers; otherwise it is a single holding register.
// A push is accepted when not full, or when a pop happens in the same cycle.
module uart_rx_fifo
    import mmio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

`ifdef MMIO_UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wptr_q;
    logic [1:0] rptr_q;
    logic [2:0] count_q;
    logic       do_pop;
    logic       do_push;

    assign do_pop  = pop_i && (count_q != 3'd0);
    assign do_push = push_i && ((count_q != 3'd4) || do_pop);

    // Pointer and occupancy tracking; pointers wrap naturally at 4
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 2'd1;
            if (do_pop)  rptr_q <= rptr_q + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign full_o  = (count_q == 3'd4);
    assign empty_o = (count_q == 3'd0);
    assign head_o  = mem_q[rptr_q];
`else
    logic [7:0] data_q;
    logic       valid_q;
    logic       valid_d;
    logic       do_pop;
    logic       do_push;

    assign do_pop  = pop_i && valid_q;
    assign do_push = push_i && (!valid_q || do_pop);

    // Occupancy of the single holding register
    always_comb begin
        valid_d = valid_q;
        if (do_push)     valid_d = 1'b1;
        else if (do_pop) valid_d = 1'b0;
    end

    // Valid flag register
    always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // Byte storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) data_q <= data_i;
    end

    assign full_o  = valid_q;
    assign empty_o = !valid_q;
    assign head_o  = data_q;
`endif

endmodule

// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART responder on the core MMIO bus.
// Registers: TXDATA (0x0), RXDATA (0x4), STATUS (0x8), DIVISOR (0xC).
// Build option MMIO_UART_RX_FIFO_EN selects a 4-entry RX FIFO instead of
// a single RX holding register (see uart_rx_fifo).
module mmio_uart
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0100,
    parameter int          CLK_HZ    = 100_000_000,
    parameter int          BAUD      = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mmio_i_addr,
    input  logic [3:0]  mmio_i_wmask,
    input  logic [31:0] mmio_i_wdata,
    output logic [31:0] mmio_o_rdata,
    input  logic        uart_i_rxd,
    output logic        uart_o_txd
);

    localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);
    localparam logic [1:0]  REG_TX    = UART_TXDATA[3:2];
    localparam logic [1:0]  REG_RX    = UART_RXDATA[3:2];
    localparam logic [1:0]  REG_ST    = UART_STATUS[3:2];
    localparam logic [1:0]  REG_DIV   = UART_DIVISOR[3:2];

    // ---------------- bus decode ----------------
    logic       sel;
    logic [1:0] reg_idx;
    logic       wr_tx;
    logic       wr_pop;
    logic       wr_status;
    logic       wr_div;
    logic       unused_bits;

    assign sel       = (mmio_i_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx   = mmio_i_addr[3:2];
    assign wr_tx     = sel && (reg_idx == REG_TX)  && mmio_i_wmask[0];
    assign wr_pop    = sel && (reg_idx == REG_RX)  && (|mmio_i_wmask);
    assign wr_status = sel && (reg_idx == REG_ST)  && mmio_i_wmask[0];
    assign wr_div    = sel && (reg_idx == REG_DIV) && (|mmio_i_wmask[1:0]);
    assign unused_bits = ^{mmio_i_addr[1:0], mmio_i_wdata[31:16]};

    // ---------------- divisor register ----------------
    logic [15:0] div_q;
    logic [15:0] div_d;

    // Byte-merge the write, then clamp to the minimum divisor
    always_comb begin
        div_d = div_q;
        if (wr_div) begin
            div_d[7:0]  = mmio_i_wmask[0] ? mmio_i_wdata[7:0]  : div_q[7:0];
            div_d[15:8] = mmio_i_wmask[1] ? mmio_i_wdata[15:8] : div_q[15:8];
            div_d       = clamp_div(div_d);
        end
    end

    // Divisor state
    always_ff @(posedge clk) begin
        if (rst) div_q <= DIV_RESET;
        else     div_q <= div_d;
    end

    // ---------------- TX path ----------------
    uart_state_t tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [15:0] tx_div_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic [7:0]  tx_hold_q;
    logic        tx_full_q;
    logic        txd_q;
    logic        tx_load;
    logic        tx_accept;

    // The shifter empties the holding register in the same edge a new
    // write lands, so a write in the load cycle is accepted.
    assign tx_load   = (tx_state_q == IDLE) && tx_full_q;
    assign tx_accept = wr_tx && (!tx_full_q || tx_load);

    // Holding register occupancy
    always_ff @(posedge clk) begin
        if (rst)            tx_full_q <= 1'b0;
        else if (tx_accept) tx_full_q <= 1'b1;
        else if (tx_load)   tx_full_q <= 1'b0;
    end

    // Holding register data
    always_ff @(posedge clk) begin
        if (tx_accept) tx_hold_q <= mmio_i_wdata[7:0];
    end

    // TX frame FSM: each state holds for the divisor latched at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= IDLE;
            txd_q      <= 1'b1;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_div_q   <= DIV_RESET;
        end else begin
            case (tx_state_q)
                IDLE: begin
                    if (tx_full_q) begin
                        tx_state_q <= START;
                        txd_q      <= 1'b0;
                        tx_shift_q <= tx_hold_q;
                        tx_div_q   <= div_q;
                        tx_cnt_q   <= div_q - 16'd1;
                    end
                end
                START: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_state_q <= DATA;
                        txd_q      <= tx_shift_q[0];
                        tx_bit_q   <= 3'd0;
                        tx_cnt_q   <= tx_div_q - 16'd1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (tx_cnt_q == 16'd0) begin
                        tx_cnt_q <= tx_div_q - 16'd1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= STOP;
                            txd_q      <= 1'b1;
                        end else begin
                            txd_q      <= tx_shift_q[1];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (tx_cnt_q == 16'd0) tx_state_q <= IDLE;
                    else                   tx_cnt_q   <= tx_cnt_q - 16'd1;
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    assign uart_o_txd = txd_q;

    // ---------------- RX path ----------------
    logic        rx_s1_q;
    logic        rx_s2_q;
    logic        rx_prev_q;
    uart_state_t rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [15:0] rx_div_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_stop_smp;
    logic        rx_push;
    logic        rx_ferr;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_i_rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // RX frame FSM: start is re-checked at mid-bit, then sample every divisor
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_div_q   <= DIV_RESET;
        end else begin
            case (rx_state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= START;
                        rx_div_q   <= div_q;
                        rx_cnt_q   <= (div_q >> 1) - 16'd1;
                    end
                end
                START: begin
                    if (rx_cnt_q == 16'd0) begin
                        if (rx_s2_q) begin
                            rx_state_q <= IDLE;
                        end else begin
                            rx_state_q <= DATA;
                            rx_bit_q   <= 3'd0;
                            rx_cnt_q   <= rx_div_q - 16'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (rx_cnt_q == 16'd0) begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_div_q - 16'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (rx_cnt_q == 16'd0) rx_state_q <= IDLE;
                    else                   rx_cnt_q   <= rx_cnt_q - 16'd1;
                end
                default: rx_state_q <= IDLE;
            endcase
        end
    end

    assign rx_stop_smp = (rx_state_q == STOP) && (rx_cnt_q == 16'd0);
    assign rx_push     = rx_stop_smp && rx_s2_q;
    assign rx_ferr     = rx_stop_smp && !rx_s2_q;

    // ---------------- RX buffer and status flags ----------------
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       rx_valid;
    logic       ovr_q;
    logic       ovr_d;
    logic       ferr_q;
    logic       ferr_d;

    uart_rx_fifo u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .data_i  (rx_shift_q),
        .pop_i   (wr_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign rx_valid = !fifo_empty;

    // Sticky error flags: a new error in the clearing cycle wins
    always_comb begin
        ovr_d  = ovr_q  & ~(wr_status & mmio_i_wdata[ST_RX_OVERRUN]);
        ferr_d = ferr_q & ~(wr_status & mmio_i_wdata[ST_FRAME_ERR]);
        if (rx_push && fifo_full && !wr_pop) ovr_d  = 1'b1;
        if (rx_ferr)                         ferr_d = 1'b1;
    end

    // Error flag state
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
        end
    end

    // ---------------- read path ----------------
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic [4:0]  status;

    always_comb begin
        status                = 5'd0;
        status[ST_TX_BUSY]    = (tx_state_q != IDLE);
        status[ST_TX_FULL]    = tx_full_q;
        status[ST_RX_VALID]   = rx_valid;
        status[ST_RX_OVERRUN] = ovr_q;
        status[ST_FRAME_ERR]  = ferr_q;
    end

    // Read mux; an empty RX buffer reads as zero rather than a stale byte
    always_comb begin
        rdata_d = 32'd0;
        if (sel) begin
            case (reg_idx)
                REG_RX:  rdata_d = {23'd0, rx_valid, rx_valid ? fifo_head : 8'h00};
                REG_ST:  rdata_d = {27'd0, status};
                REG_DIV: rdata_d = {16'd0, div_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // One-cycle registered read data
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= 32'd0;
        else     rdata_q <= rdata_d;
    end

    assign mmio_o_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: randomized self-checking bench for mmio_uart.
// Expected serial waveforms and RX buffer contents come from a behavioural
// model (frame bit formula and a byte queue) kept in this file.
`timescale 1ns/1ps
module tb_mmio_uart;

    localparam logic [31:0] BASE = 32'h1000_0100;
`ifdef MMIO_UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [3:0]  wmask = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        rxd = 1'b1;
    logic        txd;

    int n_cmp = 0;
    int n_fail = 0;

    mmio_uart dut (
        .clk          (clk),
        .rst          (rst),
        .mmio_i_addr  (addr),
        .mmio_i_wmask (wmask),
        .mmio_i_wdata (wdata),
        .mmio_o_rdata (rdata),
        .uart_i_rxd   (rxd),
        .uart_o_txd   (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // 8N1 frame: bit 0 start (low), bits 1..8 data LSB first, bit 9 stop
    function automatic logic frame_bit(input logic [7:0] d, input int k, input logic stop);
        if (k == 0) return 1'b0;
        if (k == 9) return stop;
        return d[k-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [3:0] m, input logic [31:0] d);
        addr  = BASE | {28'h0, off};
        wmask = m;
        wdata = d;
        tick();
        wmask = 4'h0;
        addr  = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] d);
        addr  = BASE | {28'h0, off};
        wmask = 4'h0;
        tick();
        d    = rdata;
        addr = 32'h0;
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop, input int div);
        for (int k = 0; k < 10; k++) begin
            rxd = frame_bit(d, k, stop);
            repeat (div) tick();
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
        n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
        bus_read(4'hC, r);
        n_cmp++; if (r !== 32'd868) begin n_fail++; $display("FAIL reset_divisor: got %0d want 868", r); end
        bus_read(4'h8, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", r); end
        bus_read(4'h4, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_rxdata: got %h want 0", r); end
        addr = 32'h1000_020C;
        tick();
        r = rdata;
        addr = 32'h0;
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL out_of_window: got %h want 0", r); end
    endtask

    task automatic test_divisor();
        logic [31:0] r;
        bus_write(4'hC, 4'b0011, 32'hFFFF_0002);
        bus_read(4'hC, r);
        n_cmp++; if (r !== 32'd4) begin n_fail++; $display("FAIL div_clamp: got %h want 4", r); end
        bus_write(4'hC, 4'b0010, 32'h0000_0300);
        bus_read(4'hC, r);
        n_cmp++; if (r !== 32'h0304) begin n_fail++; $display("FAIL div_byte1: got %h want 0304", r); end
        bus_write(4'hC, 4'b1100, 32'h1234_5678);
        bus_read(4'hC, r);
        n_cmp++; if (r !== 32'h0304) begin n_fail++; $display("FAIL div_upper_mask: got %h want 0304", r); end
    endtask

    task automatic test_tx();
        logic [31:0] r;
        logic [7:0]  d;
        logic        e;
        int          div;
        for (int i = 0; i < 4; i++) begin
            d   = (i == 0) ? 8'hA5 : 8'($urandom);
            div = (i == 0) ? 8 : int'($urandom_range(4, 12));
            bus_write(4'hC, 4'b0011, 32'(div));
            bus_write(4'h0, 4'b0001, {24'h0, d});
            n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL tx_early_start: got %b want 1", txd); end
            addr = BASE | 32'h8;
            for (int k = 0; k < 10 * div; k++) begin
                tick();
                e = frame_bit(d, k / div, 1'b1);
                n_cmp++;
                if (txd !== e) begin
                    n_fail++;
                    $display("FAIL tx_bit byte=%h div=%0d cyc=%0d: got %b want %b", d, div, k, txd, e);
                end
                if (k == 5 * div) begin
                    n_cmp++; if (rdata[0] !== 1'b1) begin n_fail++; $display("FAIL tx_busy_mid: got %b want 1", rdata[0]); end
                end
            end
            addr = 32'h0;
            repeat (3) tick();
            bus_read(4'h8, r);
            n_cmp++; if (r[1:0] !== 2'b00) begin n_fail++; $display("FAIL tx_idle_status: got %b want 00", r[1:0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] d;
        logic       e;
        int         div;
        int         w;
        int         lows;
        div = 8;
        bus_write(4'hC, 4'b0011, 32'(div));
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            if (i < 2) q.push_back(d);
            bus_write(4'h0, 4'b0001, {24'h0, d});
        end
        while (q.size() > 0) begin
            d = q.pop_front();
            w = 0;
            while (txd !== 1'b0 && w < 40) begin tick(); w++; end
            n_cmp++; if (txd !== 1'b0) begin n_fail++; $display("FAIL b2b_start_timeout: got %b want 0", txd); end
            repeat (div / 2) tick();
            for (int k = 0; k < 10; k++) begin
                if (k > 0) repeat (div) tick();
                e = frame_bit(d, k, 1'b1);
                n_cmp++; if (txd !== e) begin n_fail++; $display("FAIL b2b_bit byte=%h bit=%0d: got %b want %b", d, k, txd, e); end
            end
        end
        lows = 0;
        for (int k = 0; k < 12 * div; k++) begin tick(); if (txd !== 1'b1) lows++; end
        n_cmp++; if (lows !== 0) begin n_fail++; $display("FAIL b2b_dropped_write: got %0d low cycles want 0", lows); end
    endtask

    task automatic test_rx();
        logic [31:0] r;
        logic [7:0]  d;
        int          div;
        for (int i = 0; i < 4; i++) begin
            d   = (i == 0) ? 8'h3C : 8'($urandom);
            div = (i == 0) ? 8 : int'($urandom_range(4, 12));
            bus_write(4'hC, 4'b0011, 32'(div));
            drive_rx(d, 1'b1, div);
            repeat (4) tick();
            bus_read(4'h4, r);
            n_cmp++; if (r !== {23'h0, 1'b1, d}) begin n_fail++; $display("FAIL rx_data div=%0d: got %h want %h", div, r, {23'h0, 1'b1, d}); end
            bus_read(4'h8, r);
            n_cmp++; if (r[4:2] !== 3'b001) begin n_fail++; $display("FAIL rx_status: got %b want 001", r[4:2]); end
            bus_write(4'h4, 4'b0001, 32'h0);
            bus_read(4'h4, r);
            n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL rx_after_pop: got %h want 0", r); end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] r;
        bus_write(4'hC, 4'b0011, 32'd8);
        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        repeat (100) tick();
        bus_read(4'h8, r);
        n_cmp++; if (r[4:2] !== 3'b000) begin n_fail++; $display("FAIL glitch_status: got %b want 000", r[4:2]); end
    endtask

    task automatic test_frame_err();
        logic [31:0] r;
        bus_write(4'hC, 4'b0011, 32'd8);
        drive_rx(8'h55, 1'b0, 8);
        repeat (4) tick();
        bus_read(4'h8, r);
        n_cmp++; if (r[4:2] !== 3'b100) begin n_fail++; $display("FAIL frame_err_set: got %b want 100", r[4:2]); end
        bus_write(4'h8, 4'b0001, 32'h10);
        bus_read(4'h8, r);
        n_cmp++; if (r[4] !== 1'b0) begin n_fail++; $display("FAIL frame_err_clear: got %b want 0", r[4]); end
    endtask

    task automatic test_overrun();
        logic [31:0] r;
        logic [7:0]  q[$];
        logic [7:0]  d;
        logic        ovr;
        ovr = 1'b0;
        bus_write(4'hC, 4'b0011, 32'd8);
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = 8'($urandom);
            if (q.size() < DEPTH) q.push_back(d);
            else                  ovr = 1'b1;
            drive_rx(d, 1'b1, 8);
        end
        repeat (4) tick();
        bus_read(4'h8, r);
        n_cmp++; if (r[3:2] !== {ovr, 1'b1}) begin n_fail++; $display("FAIL overrun_status: got %b want %b", r[3:2], {ovr, 1'b1}); end
        while (q.size() > 0) begin
            d = q.pop_front();
            bus_read(4'h4, r);
            n_cmp++; if (r !== {23'h0, 1'b1, d}) begin n_fail++; $display("FAIL overrun_order: got %h want %h", r, {23'h0, 1'b1, d}); end
            bus_write(4'h4, 4'b1000, 32'h0);
        end
        bus_read(4'h4, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL overrun_drained: got %h want 0", r); end
        bus_write(4'h8, 4'b0001, 32'h08);
        bus_read(4'h8, r);
        n_cmp++; if (r[3] !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", r[3]); end
    endtask

    task automatic test_rx_random();
        logic [31:0] r;
        logic [31:0] e;
        logic [7:0]  q[$];
        logic [7:0]  d;
        logic        ovr;
        ovr = 1'b0;
        bus_write(4'hC, 4'b0011, 32'd6);
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                d = 8'($urandom);
                if (q.size() < DEPTH) q.push_back(d);
                else                  ovr = 1'b1;
                drive_rx(d, 1'b1, 6);
                repeat (4) tick();
            end else begin
                if (q.size() > 0) void'(q.pop_front());
                bus_write(4'h4, 4'b0001, 32'h0);
            end
            e = (q.size() > 0) ? {23'h0, 1'b1, q[0]} : 32'h0;
            bus_read(4'h4, r);
            n_cmp++; if (r !== e) begin n_fail++; $display("FAIL rx_rand_head step=%0d: got %h want %h", i, r, e); end
            bus_read(4'h8, r);
            n_cmp++; if (r[3:2] !== {ovr, q.size() > 0}) begin n_fail++; $display("FAIL rx_rand_status step=%0d: got %b want %b", i, r[3:2], {ovr, q.size() > 0}); end
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] r;
        int          highs;
        bus_write(4'hC, 4'b0011, 32'd8);
        bus_write(4'h0, 4'b0001, 32'h00);
        repeat (20) tick();
        n_cmp++; if (txd !== 1'b0) begin n_fail++; $display("FAIL mid_tx_low: got %b want 0", txd); end
        rst = 1'b1;
        tick();
        n_cmp++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_mid_tx_txd: got %b want 1", txd); end
        rst = 1'b0;
        highs = 0;
        for (int k = 0; k < 100; k++) begin tick(); if (txd === 1'b1) highs++; end
        n_cmp++; if (highs !== 100) begin n_fail++; $display("FAIL reset_tx_abort: got %0d high cycles want 100", highs); end
        bus_read(4'h8, r);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_mid_status: got %h want 0", r); end
        bus_read(4'hC, r);
        n_cmp++; if (r !== 32'd868) begin n_fail++; $display("FAIL reset_mid_divisor: got %0d want 868", r); end
    endtask

    initial begin
        test_reset();
        test_divisor();
        test_tx();
        test_back_to_back();
        test_rx();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_rx_random();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart.md
# mmio_uart

Memory-mapped UART peripheral that acts as a responder on the core's MMIO bus (`addr`/`wmask`/`wdata`/`rdata`) and drives the board UART pins. It takes bytes written by firmware, serialises them as 8N1 frames on the TX pin, and deserialises incoming frames into a receive buffer that firmware polls. It sits beside `mmio` under `z1top` and shares its bus; `mmio` returns zero for this block's address window.

## Interface
- `BASE_ADDR`, 32'h1000_0100: base of the 16-byte register window; decode is `mmio_i_addr[31:4] == BASE_ADDR[31:4]`.
- `CLK_HZ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 115_200: reset baud rate; reset divisor = CLK_HZ/BAUD, truncated, which is 868.
- `clk` in 1: the single system clock.
- `rst` in 1: synchronous, active-high reset.
- `mmio_i_addr` in 32: byte address; bits [3:2] select the register.
- `mmio_i_wmask` in 4: byte write enables; all-zero means no write.
- `mmio_i_wdata` in 32: write data.
- `mmio_o_rdata` out 32: registered read data; it is 0 when the address is outside the window.
- `uart_i_rxd` in 1: serial input, asynchronous, idles high.
- `uart_o_txd` out 1: serial output, idles high.

## Operation
- Register map (offset: register):
  - 0x0 TXDATA. A write with `wmask[0]` loads `wdata[7:0]` into the TX holding register. If the holding register is already full, the write is dropped. Reads return 0.
  - 0x4 RXDATA. Reads return `{23'b0, rx_valid, rx_byte}` and have no side effect. Any write with a nonzero `wmask` pops the head entry; a pop when empty is ignored.
  - 0x8 STATUS. Bits:
    - bit0 `tx_busy`: shifter active.
    - bit1 `tx_full`: holding register occupied.
    - bit2 `rx_valid`.
    - bit3 `rx_overrun`: sticky.
    - bit4 `frame_err`: sticky.
    - A write with `wmask[0]` clears bit3 and/or bit4 where `wdata` has a 1.
  - 0xC DIVISOR. Bits [15:0] are clock cycles per bit; writable with `wmask[1:0]`. A written value below 4 is clamped to 4. A change takes effect at the next frame start, never mid-frame.
- TX path:
  - State machine: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - Each state holds for DIVISOR cycles.
  - In IDLE with the holding register full, the shifter loads from the holding register and clears `tx_full`.
- RX path:
  - `uart_i_rxd` passes through a 2-flop synchroniser.
  - State machine: IDLE → START → DATA → STOP.
  - A falling edge in IDLE enters START. The line is sampled at DIVISOR/2; if it is high, the start is treated as a glitch and the FSM returns to IDLE.
  - Data bits and the stop bit are each sampled every DIVISOR cycles after that.
  - Stop bit high: push the byte to the RX buffer.
  - Stop bit low: set `frame_err` and discard the byte.
  - Push into a full buffer: drop the new byte and set `rx_overrun`.
- Simultaneous events:
  - A pop and a push in the same cycle both take effect; the count is unchanged.
  - A TXDATA write in the same cycle the shifter loads is accepted, because `tx_full` clears first.
  - A STATUS clear and a new error in the same cycle leave the flag set.
- Reset mid-frame aborts both FSMs. `uart_o_txd` goes to 1 in the reset cycle, and a partial RX byte is discarded.

## Timing
- Read latency is 1 cycle: the address presented in cycle N produces `mmio_o_rdata` in cycle N+1. Writes commit at the clock edge ending cycle N.
- TX: a TXDATA write in cycle N on an idle block gives start-bit low from cycle N+2. A full frame is 10×DIVISOR cycles, and `tx_busy` deasserts after the last stop cycle.
- RX: `rx_valid` rises 2 (synchroniser) + DIVISOR/2 + 9×DIVISOR cycles (±1) after the start edge reaches the pin.
- Reset values:
  - `mmio_o_rdata` = 0.
  - `uart_o_txd` = 1.
  - DIVISOR = CLK_HZ/BAUD.
  - All flags 0, RX buffer empty, both FSMs in IDLE.

## Configuration
- `MMIO_UART_RX_FIFO_EN` defined: the RX buffer is a 4-entry FIFO with a 2-bit pointer that wraps, and overrun occurs on the 5th unpopped byte.
- Not defined: the RX buffer is a single holding register, and overrun occurs on the 2nd unpopped byte.
- The register map and STATUS bits are identical in both builds.

## Structure
- Shared package `mmio_pkg`:
  - register offset constants: `UART_TXDATA`, `UART_RXDATA`, `UART_STATUS`, `UART_DIVISOR`.
  - STATUS bit index constants.
  - `uart_state_t` enum: IDLE, START, DATA, STOP.
  - `UART_DIV_MIN` = 4.
- One sub-module: `uart_rx_fifo`. It is the RX buffer, with push/pop/full/empty/head ports and the depth selected by the macro. The TX and RX FSMs stay in `mmio_uart`.

## Test plan
- Reset, then read 0xC → 868. Read 0x8 → 0. Check `uart_o_txd` = 1.
- Write DIVISOR=8, then write TXDATA=0xA5 → `uart_o_txd` shows 0,1,0,1,0,0,1,0,1,1. Each bit lasts 8 cycles, and the start bit appears 2 cycles after the write. STATUS bit0 reads 1 during the frame.
- DIVISOR=8: drive RX frame 0x3C → after about 80 cycles, reading 0x4 gives 0x13C. Write 0x4 → the next read gives 0x000.
- DIVISOR=8: drive a 4-cycle low glitch → no byte is received and `frame_err` stays 0.
- Drive frame 0x55 with stop bit 0 → STATUS bit4 = 1 and no byte is received. Write 0x10 to 0x8 → bit4 clears.
- Send 5 bytes without popping (FIFO build; 2 bytes in the no-FIFO build) → STATUS bit3 = 1 and the head is still the 1st byte. Reset mid-TX-frame → `uart_o_txd` = 1 on the next cycle.
